lcd_rect_fill: RTL and testbench

Parametrised rectangle-fill engine for the 16-bit 8080-style LCD bus. It replaces the fixed two-block colour sequence and its hard-coded address-window commands. It accepts a rectangle command (x, y, w, h, colour, mode), clips it to the panel, and emits the column-window, row-window and memory-write command sequence followed by the pixel words. Pixels come either from a constant colour (fill mode) or from an upstream valid/ready stream (stream mode). It sits after panel initialisation and shares the LCD bus through the existing CS/WR mux.

---
 rtl/lcd_rect_fill_pkg.sv | 18 +
 rtl/lcd_rect_fill_bus_word.sv | 50 +++++
 rtl/lcd_rect_fill.sv | 130 +++++++++++++
 tb/tb_lcd_rect_fill.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rect_fill_pkg.sv
// lcd_pkg: LCD opcodes, engine states and setup word indices
package lcd_pkg;
  localparam logic [7:0] LCD_CASET = 8'h2A;
  localparam logic [7:0] LCD_PASET = 8'h2B;
  localparam logic [7:0] LCD_RAMWR = 8'h2C;
  typedef enum logic [2:0] {IDLE, SETUP, PIX, END, ERR} state_t;
  localparam logic [3:0] W_CASET = 4'd0;
  localparam logic [3:0] W_XS_HI = 4'd1;
  localparam logic [3:0] W_XS_LO = 4'd2;
  localparam logic [3:0] W_XE_HI = 4'd3;
  localparam logic [3:0] W_XE_LO = 4'd4;
  localparam logic [3:0] W_PASET = 4'd5;
  localparam logic [3:0] W_YS_HI = 4'd6;
  localparam logic [3:0] W_YS_LO = 4'd7;
  localparam logic [3:0] W_YE_HI = 4'd8;
  localparam logic [3:0] W_YE_LO = 4'd9;
  localparam logic [3:0] W_RAMWR = 4'd10;
endpackage

// File: rtl/lcd_rect_fill_bus_word.sv
// lcd_bus_word: shapes one bus word as WR_LOW low then WR_HIGH high cycles of lcd_wr
module lcd_bus_word #(
  parameter int DATA_WIDTH = 16,
  parameter int WR_LOW = 1,
  parameter int WR_HIGH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  word_rs,
  input  logic [DATA_WIDTH-1:0] word_data,
  output logic                  lcd_wr,
  output logic                  lcd_rs,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  active,
  output logic                  word_done
);
  localparam int PER = WR_LOW + WR_HIGH;
  localparam int CB = $clog2(PER);
  localparam logic [CB-1:0] LOW = CB'(WR_LOW);
  localparam logic [CB-1:0] LAST = CB'(PER - 1);
  localparam logic [CB-1:0] ONE = CB'(1);
  logic [CB-1:0] cnt, cur;
  logic [DATA_WIDTH-1:0] data_q;
  logic rs_q, run;
  assign run = start || active;
  assign cur = start ? '0 : cnt;
  assign lcd_wr = !(run && cur < LOW);
  assign lcd_data = start ? word_data : data_q;
  assign lcd_rs = start ? word_rs : rs_q;
  assign word_done = run && cur == LAST;
  // phase counter and held word; data/rs stay put between words so a stall keeps the bus steady
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt <= '0;
      data_q <= '0;
      rs_q <= 1'b1;
    end else begin
      if (run) begin
        cnt <= word_done ? '0 : cur + ONE;
        active <= !word_done;
      end
      if (start) begin
        data_q <= word_data;
        rs_q <= word_rs;
      end
    end
  end
endmodule

// File: rtl/lcd_rect_fill.sv
// lcd_rect_fill: clips a rectangle, emits window/RAMWR commands, then fill or streamed pixels
module lcd_rect_fill import lcd_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int COORD_WIDTH = 16,
  parameter int PANEL_W = 240,
  parameter int PANEL_H = 320,
  parameter int WR_LOW = 1,
  parameter int WR_HIGH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic [COORD_WIDTH-1:0] cmd_w,
  input  logic [COORD_WIDTH-1:0] cmd_h,
  input  logic [DATA_WIDTH-1:0]  cmd_color,
  input  logic                   cmd_stream,
  input  logic [DATA_WIDTH-1:0]  pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   lcd_cs,
  output logic                   lcd_wr,
  output logic                   lcd_rs,
  output logic [DATA_WIDTH-1:0]  lcd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int CW = COORD_WIDTH;
  localparam logic [CW:0] PW = (CW + 1)'(PANEL_W);
  localparam logic [CW:0] PH = (CW + 1)'(PANEL_H);
  localparam logic [CW:0] ONE1 = (CW + 1)'(1);
  localparam logic [2*CW-1:0] ONE2 = (2 * CW)'(1);
  state_t state, state_n;
  logic [CW-1:0] x, y, xe, ye;
  logic [CW:0] sx, sy, xc, yc, cols, rows;
  logic [2*CW-1:0] left, npix;
  logic [DATA_WIDTH-1:0] color, setup_word, word_data;
  logic [3:0] idx;
  logic stream, reject, start, word_rs, active, word_done;
  assign sx = {1'b0, cmd_x} + {1'b0, cmd_w} - ONE1;
  assign sy = {1'b0, cmd_y} + {1'b0, cmd_h} - ONE1;
  assign xc = sx >= PW ? PW - ONE1 : sx;
  assign yc = sy >= PH ? PH - ONE1 : sy;
  assign reject = cmd_w == '0 || cmd_h == '0 || {1'b0, cmd_x} >= PW || {1'b0, cmd_y} >= PH;
  assign cols = {1'b0, xe} - {1'b0, x} + ONE1;
  assign rows = {1'b0, ye} - {1'b0, y} + ONE1;
  assign npix = (2 * CW)'(cols) * (2 * CW)'(rows);
  assign cmd_ready = state == IDLE;
  assign busy = state == SETUP || state == PIX || state == END;
  assign done = state == END;
  assign err = state == ERR;
  assign lcd_cs = !(state == SETUP || state == PIX);
  assign start = !lcd_cs && !active && (state == SETUP || !stream || pix_valid);
  assign pix_ready = start && state == PIX && stream;
  assign word_rs = !(state == SETUP && (idx == W_CASET || idx == W_PASET || idx == W_RAMWR));
  assign word_data = state == SETUP ? setup_word : (stream ? pix_data : color);
  // setup word selection: opcodes and zero-extended high/low coordinate bytes
  always_comb begin
    setup_word = '0;
    case (idx)
      W_CASET: setup_word = DATA_WIDTH'(LCD_CASET);
      W_XS_HI: setup_word = DATA_WIDTH'(x >> 8);
      W_XS_LO: setup_word = DATA_WIDTH'(x[7:0]);
      W_XE_HI: setup_word = DATA_WIDTH'(xe >> 8);
      W_XE_LO: setup_word = DATA_WIDTH'(xe[7:0]);
      W_PASET: setup_word = DATA_WIDTH'(LCD_PASET);
      W_YS_HI: setup_word = DATA_WIDTH'(y >> 8);
      W_YS_LO: setup_word = DATA_WIDTH'(y[7:0]);
      W_YE_HI: setup_word = DATA_WIDTH'(ye >> 8);
      W_YE_LO: setup_word = DATA_WIDTH'(ye[7:0]);
      W_RAMWR: setup_word = DATA_WIDTH'(LCD_RAMWR);
      default: setup_word = '0;
    endcase
  end
  // next state: rejects bounce through ERR, accepted commands walk SETUP -> PIX -> END
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cmd_valid ? (reject ? ERR : SETUP) : IDLE;
      SETUP: state_n = word_done && idx == W_RAMWR ? PIX : SETUP;
      PIX: state_n = word_done && left == ONE2 ? END : PIX;
      default: state_n = IDLE;
    endcase
  end
  // state, captured command with clipped corners, setup index and remaining pixel count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      xe <= '0;
      ye <= '0;
      color <= '0;
      stream <= 1'b0;
      idx <= '0;
      left <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        x <= cmd_x;
        y <= cmd_y;
        xe <= xc[CW-1:0];
        ye <= yc[CW-1:0];
        color <= cmd_color;
        stream <= cmd_stream;
        idx <= '0;
      end
      if (state == SETUP && word_done) begin
        idx <= idx + 4'd1;
        left <= npix;
      end
      if (state == PIX && word_done) left <= left - ONE2;
    end
  end
  lcd_bus_word #(.DATA_WIDTH(DATA_WIDTH), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) u_word (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_rs(word_rs),
    .word_data(word_data),
    .lcd_wr(lcd_wr),
    .lcd_rs(lcd_rs),
    .lcd_data(lcd_data),
    .active(active),
    .word_done(word_done)
  );
endmodule

// File: tb/tb_lcd_rect_fill.sv
// tb_lcd_rect_fill: table-driven scoreboard bench for the rectangle fill engine
`timescale 1ns/1ps
module tb_lcd_rect_fill;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cmd_valid, cmd_valid2, cmd_stream, pix_valid;
  logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, pix_data;
  logic cmd_ready, pix_ready, lcd_cs, lcd_wr, lcd_rs, busy, done, err;
  logic [15:0] lcd_data;
  logic cmd_ready2, pix_ready2, lcd_cs2, lcd_wr2, lcd_rs2, busy2, done2, err2;
  logic [15:0] lcd_data2;
  lcd_rect_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_stream(cmd_stream),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .lcd_cs(lcd_cs), .lcd_wr(lcd_wr), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .busy(busy), .done(done), .err(err)
  );
  lcd_rect_fill #(.WR_LOW(2), .WR_HIGH(3)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_stream(cmd_stream),
    .pix_data(pix_data), .pix_valid(1'b0), .pix_ready(pix_ready2),
    .lcd_cs(lcd_cs2), .lcd_wr(lcd_wr2), .lcd_rs(lcd_rs2), .lcd_data(lcd_data2),
    .busy(busy2), .done(done2), .err(err2)
  );
  typedef struct {
    logic [15:0] x, y, w, h, color;
    bit rej;
    logic [15:0] xe, ye;
    int p;
  } vec_t;
  int tests = 0, fails = 0;
  logic [16:0] expq[$];
  logic [15:0] spix[$];
  int stall_at = -1, stall_len = 0, poke = 0;
  int cs_low, done_n, err_n, busy_n, pr_n, first_cs, extra, stall_bad;
  int ph, bad, seen;
  vec_t v[9];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void push_hdr(input logic [15:0] x, y, xe, ye);
    expq.push_back({1'b0, 16'h002A});
    expq.push_back({1'b1, 8'h00, x[15:8]});
    expq.push_back({1'b1, 8'h00, x[7:0]});
    expq.push_back({1'b1, 8'h00, xe[15:8]});
    expq.push_back({1'b1, 8'h00, xe[7:0]});
    expq.push_back({1'b0, 16'h002B});
    expq.push_back({1'b1, 8'h00, y[15:8]});
    expq.push_back({1'b1, 8'h00, y[7:0]});
    expq.push_back({1'b1, 8'h00, ye[15:8]});
    expq.push_back({1'b1, 8'h00, ye[7:0]});
    expq.push_back({1'b0, 16'h002C});
  endfunction
  task automatic check_reset_state(input string name);
    check(name, {lcd_cs, lcd_wr, lcd_rs, busy, done, err, pix_ready, cmd_ready}, 8'b1110_0001);
    check({name, "_data"}, lcd_data, 16'h0000);
  endtask
  task automatic watch(input int limit);
    logic pw;
    logic consumed;
    logic [16:0] e;
    int k;
    int sl;
    bit fin;
    pw = 1'b1; k = 0; sl = stall_len; fin = 0;
    cs_low = 0; done_n = 0; err_n = 0; busy_n = 0; pr_n = 0; first_cs = -1; extra = 0; stall_bad = 0;
    for (int n = 0; n < limit && !fin; n++) begin
      @(negedge clk);
      if (!lcd_cs) begin
        cs_low++;
        if (first_cs < 0) first_cs = n;
      end
      busy_n += int'(busy);
      done_n += int'(done);
      err_n += int'(err);
      pr_n += int'(pix_ready);
      if (poke != 0 && n == poke) check("cmd_ready_while_busy", cmd_ready, 0);
      if (!pix_valid && k == stall_at && (lcd_cs || !lcd_wr || lcd_data !== spix[k-1])) stall_bad++;
      if (lcd_wr && !pw && !lcd_cs) begin
        if (expq.size() == 0) extra++;
        else begin
          e = expq.pop_front();
          check("word", {15'd0, lcd_rs, lcd_data}, {15'd0, e});
        end
      end
      pw = lcd_wr;
      consumed = pix_ready;
      fin = done || err;
      @(posedge clk);
      #1;
      if (consumed) k++;
      if (poke != 0) cmd_valid = (n + 1 == poke);
      if (spix.size() > 0) begin
        if (k == stall_at && sl > 0) begin
          pix_valid = 1'b0;
          sl--;
        end else if (k < spix.size()) begin
          pix_valid = 1'b1;
          pix_data = spix[k];
        end else pix_valid = 1'b0;
      end
    end
  endtask
  task automatic run(input vec_t c, input bit strm, input int stall_extra);
    int exp_cs;
    expq.delete();
    if (!c.rej) begin
      push_hdr(c.x, c.y, c.xe, c.ye);
      if (strm) foreach (spix[j]) expq.push_back({1'b1, spix[j]});
      else repeat (c.p) expq.push_back({1'b1, c.color});
    end
    exp_cs = (11 + c.p) * 2 + stall_extra;
    cmd_x = c.x; cmd_y = c.y; cmd_w = c.w; cmd_h = c.h; cmd_color = c.color;
    cmd_stream = strm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    watch(3000);
    if (c.rej) begin
      check("reject_err", err_n, 1);
      check("reject_cs", cs_low, 0);
      check("reject_busy", busy_n, 0);
      check("reject_done", done_n, 0);
      check("reject_ready_back", {cmd_ready, busy}, 2'b10);
    end else begin
      check("done_count", done_n, 1);
      check("err_count", err_n, 0);
      check("first_word_latency", first_cs, 0);
      check("cs_low_cycles", cs_low, exp_cs);
      check("busy_cycles", busy_n, exp_cs + 1);
      check("words_missing", expq.size(), 0);
      check("words_extra", extra, 0);
      if (!strm) check("fill_pix_ready", pr_n, 0);
    end
  endtask
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_stream = 1'b0;
    pix_valid = 1'b1; pix_data = 16'h1234;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    v[0] = '{16'd10, 16'd20, 16'd20, 16'd20, 16'hF800, 1'b0, 16'h001D, 16'h0027, 400};
    v[1] = '{16'd230, 16'd310, 16'd20, 16'd20, 16'h07E0, 1'b0, 16'h00EF, 16'h013F, 100};
    v[2] = '{16'd5, 16'd5, 16'd0, 16'd4, 16'h1111, 1'b1, 16'h0, 16'h0, 0};
    v[3] = '{16'd240, 16'd0, 16'd4, 16'd4, 16'h2222, 1'b1, 16'h0, 16'h0, 0};
    v[4] = '{16'd0, 16'd320, 16'd4, 16'd4, 16'h3333, 1'b1, 16'h0, 16'h0, 0};
    v[5] = '{16'd239, 16'd319, 16'd1, 16'd1, 16'h001F, 1'b0, 16'h00EF, 16'h013F, 1};
    v[6] = '{16'd0, 16'd0, 16'd3, 16'd2, 16'hABCD, 1'b0, 16'h0002, 16'h0001, 6};
    v[7] = '{16'd200, 16'd0, 16'hFFFF, 16'd1, 16'h0F0F, 1'b0, 16'h00EF, 16'h0000, 40};
    v[8] = '{16'd1, 16'd1, 16'd3, 16'd0, 16'h4444, 1'b1, 16'h0, 16'h0, 0};
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_reset", cmd_ready, 1);
    foreach (v[i]) begin
      poke = (i == 6) ? 5 : 0;
      run(v[i], 1'b0, 0);
    end
    poke = 0;
    spix = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    stall_at = 2; stall_len = 5;
    pix_data = spix[0]; pix_valid = 1'b1;
    run('{16'd7, 16'd8, 16'd2, 16'd2, 16'h0000, 1'b0, 16'h0008, 16'h0009, 4}, 1'b1, 4);
    check("stream_pix_ready", pr_n, 4);
    check("stream_stall_bus", stall_bad, 0);
    spix.delete();
    stall_at = -1; stall_len = 0; pix_valid = 1'b1;
    cmd_x = 16'd5; cmd_y = 16'd6; cmd_w = 16'd1; cmd_h = 16'd1; cmd_color = 16'h1234; cmd_stream = 1'b0;
    cmd_valid2 = 1'b1;
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
    ph = 0; bad = 0; seen = 0;
    for (int n = 0; n < 300 && seen == 0; n++) begin
      @(negedge clk);
      if (!lcd_cs2) begin
        if (lcd_wr2 !== ((ph % 5) >= 2)) bad++;
        ph++;
      end
      seen = int'(done2);
    end
    check("wr23_shape", bad, 0);
    check("wr23_cs_low", ph, 60);
    check("wr23_done", seen, 1);
    @(posedge clk);
    #1;
    cmd_x = 16'd0; cmd_y = 16'd0; cmd_w = 16'd20; cmd_h = 16'd20; cmd_color = 16'h5555;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (120) @(posedge clk);
    #1 check("pixel50_active", {lcd_cs, lcd_wr, lcd_data}, {2'b00, 16'h5555});
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_state("mid_reset_state");
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(done) + int'(err) + int'(!lcd_cs);
    end
    check("no_done_after_reset", seen, 0);
    run('{16'd3, 16'd4, 16'd2, 16'd1, 16'h0A0A, 1'b0, 16'h0004, 16'h0004, 2}, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
